// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with fixed-latency stalled reads, 1-cycle writes, sticky error.
// Define MEM_WSTRB_EN to add the per-byte write strobe port mem_wstrb.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        cpu_rst,
    input  logic        cpu_en,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
`ifdef MEM_WSTRB_EN
    input  logic [3:0]  mem_wstrb,
`endif
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_valid,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

    state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rd_q, rd_d;
    logic [31:0] din_q, din_d;
    logic        err_q, err_d;

    logic [31:0] ram [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic        misal, oor, confl, bad;
    logic        wr_en;
    logic [3:0]  be;
    logic [31:0] word;

    assign idx   = mem_addr[ADDR_WIDTH+1:2];
    assign misal = |mem_addr[1:0];
    assign oor   = |mem_addr[31:ADDR_WIDTH+2];
    assign confl = mem_ren & mem_wen;
    assign bad   = misal | oor | confl;
    assign word  = bad ? 32'h0 : ram[idx];

`ifdef MEM_WSTRB_EN
    assign be = mem_wstrb;
`else
    assign be = 4'hF;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        din_d     = din_q;
        err_d     = err_q;
        wr_en     = 1'b0;
        mem_stall = 1'b0;
        mem_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                mem_stall = mem_ren;
                if (cpu_en) begin
                    if (mem_ren) begin
                        rd_d    = word;
                        cnt_d   = LAT_M1;
                        state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
                        // With single-cycle latency the response register loads directly
                        if (LATENCY == 1) din_d = word;
                    end else if (mem_wen) begin
                        wr_en = ~bad;
                    end
                    if ((mem_ren | mem_wen) & bad) err_d = 1'b1;
                end
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                if (cpu_en) begin
                    if (cnt_q == 3'd1) begin
                        state_d = S_RESP;
                        din_d   = rd_q;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            S_RESP: begin
                mem_valid = 1'b1;
                if (cpu_en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            rd_q    <= 32'h0;
            din_q   <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            din_q   <= din_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset; only the write is suppressed while it is held
    always_ff @(posedge clk) begin
        if (wr_en && !cpu_rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram[idx][8*b +: 8] <= mem_dout[8*b +: 8];
            end
        end
    end

    assign mem_din = din_q;
    assign mem_err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a transaction-level model.
// Define MEM_WSTRB_EN to also exercise the byte-strobe write path.
module tb_data_mem_responder;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        cpu_rst;
    logic        cpu_en;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        mem_valid;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [2**AW];
    logic        err_exp;

    data_mem_responder #(
        .ADDR_WIDTH(AW),
        .LATENCY   (LAT)
    ) dut (
        .clk      (clk),
        .cpu_rst  (cpu_rst),
        .cpu_en   (cpu_en),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
`ifdef MEM_WSTRB_EN
        .mem_wstrb(mem_wstrb),
`endif
        .mem_din  (mem_din),
        .mem_stall(mem_stall),
        .mem_valid(mem_valid),
        .mem_err  (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        logic [AW-1:0] i;
        mem_wen  = 1'b1;
        mem_addr = a;
        mem_dout = d;
        @(negedge clk);
        check("wr_stall", mem_stall, 1'b0);
        @(posedge clk);
        #1;
        mem_wen = 1'b0;
        i = a[AW+1:2];
        if (legal(a)) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) model[i][8*b +: 8] = d[8*b +: 8];
        end else begin
            err_exp = 1'b1;
        end
        check("wr_err", mem_err, err_exp);
    endtask

    task automatic do_read(input logic [31:0] a, input bit confl,
                           input int freeze);
        logic [31:0] exp;
        int n;
        bit found;
        exp = (legal(a) && !confl) ? model[a[AW+1:2]] : 32'h0;
        if (!legal(a) || confl) err_exp = 1'b1;
        mem_ren  = 1'b1;
        mem_wen  = confl;
        mem_addr = a;
        mem_dout = $urandom;
        @(negedge clk);
        check("rd_stall0", mem_stall, 1'b1);
        check("rd_valid0", mem_valid, 1'b0);
        @(posedge clk);
        #1;
        mem_wen = 1'b0;
        n = 1;
        found = 0;
        while (n < 40 && !found) begin
            cpu_en = (n <= freeze) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (mem_valid) begin
                found = 1;
            end else begin
                check("rd_stall", mem_stall, 1'b1);
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("rd_lat", n, LAT + freeze);
        check("rd_data", mem_din, exp);
        check("rd_err", mem_err, err_exp);
        @(posedge clk);
        #1;
        mem_ren = 1'b0;
        cpu_en  = 1'b1;
        @(negedge clk);
        check("rd_after_valid", mem_valid, 1'b0);
        check("rd_hold", mem_din, exp);
        check("rd_after_stall", mem_stall, 1'b0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int r;
        a = 32'($urandom_range(0, 15)) << 2;
        r = $urandom_range(0, 9);
        if (r == 8) a = a + 32'($urandom_range(1, 3));
        if (r == 9) a = a | (32'h1 << $urandom_range(AW + 2, 31));
        return a;
    endfunction

    initial begin
        logic [1:0] stl_e [6];
        logic [1:0] vld_e [6];
        stl_e = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0};
        vld_e = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
        cpu_rst   = 1'b1;
        cpu_en    = 1'b1;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_dout  = '0;
        mem_wstrb = 4'hF;
        err_exp   = 1'b0;
        #2;
        check("rst_din", mem_din, 32'h0);
        check("rst_valid", mem_valid, 1'b0);
        check("rst_err", mem_err, 1'b0);
        check("rst_stall", mem_stall, 1'b0);
        @(posedge clk);
        #1;
        cpu_rst = 1'b0;

        do_write(32'h10, 32'h1234_5678);
        do_read(32'h10, 0, 0);

        do_write(32'h0, 32'hA);
        do_write(32'h4, 32'hB);
        mem_ren  = 1'b1;
        mem_addr = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("b2b_stall", mem_stall, 1'(stl_e[c]));
            check("b2b_valid", mem_valid, 1'(vld_e[c]));
            if (c >= 2)
                check("b2b_din", mem_din, (c == 5) ? 32'hB : 32'hA);
            @(posedge clk);
            #1;
            if (c == 2) mem_addr = 32'h4;
        end
        mem_ren = 1'b0;

        do_write(32'h13, 32'hFFFF_FFFF);
        do_read(32'h10, 0, 0);
        do_read(32'h10, 0, 3);

        // asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        cpu_rst = 1'b1;
        #1;
        check("arst_din", mem_din, 32'h0);
        check("arst_valid", mem_valid, 1'b0);
        check("arst_err", mem_err, 1'b0);
        check("arst_stall", mem_stall, 1'b0);
        err_exp = 1'b0;
        @(posedge clk);
        #1;
        cpu_rst = 1'b0;

        // reset while waiting aborts the read
        mem_ren  = 1'b1;
        mem_addr = 32'h10;
        @(posedge clk);
        #1;
        mem_ren = 1'b0;
        #2;
        cpu_rst = 1'b1;
        #1;
        check("abort_valid", mem_valid, 1'b0);
        check("abort_stall", mem_stall, 1'b0);
        check("abort_din", mem_din, 32'h0);
        @(posedge clk);
        #1;
        cpu_rst = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            check("abort_novalid", mem_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        do_read(32'h10, 0, 0);

`ifdef MEM_WSTRB_EN
        mem_wstrb = 4'b0011;
        do_write(32'h10, 32'hAABB_CCDD);
        mem_wstrb = 4'hF;
        do_read(32'h10, 0, 0);
        check("wstrb_model", model[4], 32'h1234_CCDD);
`endif

        for (int i = 0; i < 16; i++) do_write(32'(i) << 2, $urandom);
        for (int k = 0; k < 80; k++) begin
            int op;
            op = $urandom_range(0, 9);
`ifdef MEM_WSTRB_EN
            mem_wstrb = 4'($urandom);
`endif
            if (op < 4) begin
                do_write(rand_addr(), $urandom);
            end else if (op < 9) begin
                do_read(rand_addr(), 0,
                        ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
            end else begin
                do_read(rand_addr(), 1, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU data-memory port. It owns a word-addressed RAM and answers the datapath's `mem_ren`/`mem_wen`/`mem_addr`/`mem_dout` requests. Reads have a fixed multi-cycle latency signalled with a stall/valid handshake. Writes complete in one cycle. Every illegal access is flagged in a sticky error bit. It sits between the pipelined datapath's MEM stage and the board-level data RAM.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-address width; RAM depth is 2^ADDR_WIDTH words.
- `LATENCY`, default 2: read latency in cycles; legal range 1..7.

Ports:
- `clk`  in  1  main clock; all state changes on the rising edge.
- `cpu_rst`  in  1  reset; **asynchronous, active-high**.
- `cpu_en`  in  1  global enable; low freezes the FSM, the counter and writes.
- `mem_ren`  in  1  read request; held by the CPU until accepted.
- `mem_wen`  in  1  write request.
- `mem_addr`  in  32  byte address.
- `mem_dout`  in  32  write data from the CPU.
- `mem_din`  out  32  read data to the CPU; registered.
- `mem_stall`  out  1  CPU must hold its request and pipeline.
- `mem_valid`  out  1  one-cycle pulse: `mem_din` carries the requested word.
- `mem_err`  out  1  sticky access-error flag.

## Operation
- Word index is `mem_addr[ADDR_WIDTH+1:2]`.
- **Misaligned:** `mem_addr[1:0]!=0`.
- **Out of range:** any bit of `mem_addr[31:ADDR_WIDTH+2]` set.
- **Conflict:** `mem_ren` and `mem_wen` both high.
- FSM states: IDLE, WAIT, RESP. Counter `cnt` is 3 bits.
- **IDLE, `mem_ren` only:**
  - `mem_stall=1` combinationally.
  - At the edge, the array word is captured into the read register (0 if illegal), `cnt<=LATENCY-1`, and the FSM moves to WAIT (LATENCY>1) or RESP (LATENCY=1).
- **IDLE, `mem_wen` only:**
  - Legal address: the word is written at the edge.
  - No stall; the FSM stays in IDLE.
- **Illegal access (misaligned, out of range, or conflict):** no array write; `mem_err<=1` at the edge.
  - Illegal read: runs normal timing and returns 0.
  - Conflict: the write is dropped and the read proceeds.
- **WAIT:**
  - `mem_stall=1`.
  - If `cnt==1`, go to RESP; otherwise `cnt<=cnt-1`.
- **RESP:**
  - `mem_valid=1`, `mem_stall=0`, `mem_din` = captured word.
  - Next state is IDLE.
  - Requests present during RESP are not accepted; the CPU advances at this edge.
- Requests are only sampled in IDLE. Write requests in WAIT/RESP are ignored, because the CPU is stalled.
- `mem_din` holds its last read value outside RESP.
- `mem_err` clears only on reset.
- **`cpu_en=0`:**
  - State, `cnt`, the read register and `mem_err` hold; no write occurs.
  - `mem_stall`/`mem_valid` keep the values decoded from the frozen state.
- **Reset:**
  - Async assert: FSM goes to IDLE; `cnt`, `mem_din` and `mem_err` go to 0.
  - Outputs settle without a clock edge: `mem_stall=0` (request-dependent in IDLE), `mem_valid=0`.
  - RAM contents are not cleared.

## Timing
- Read accepted in cycle 0; `mem_valid` in cycle LATENCY; `mem_stall` high in cycles 0..LATENCY-1.
- A CPU read occupies LATENCY+1 cycles. Back-to-back reads: the next accept is in cycle LATENCY+1.
- Writes: zero stall, one cycle. A read in the cycle after a write returns the new data.
- `mem_stall` in IDLE is combinational from `mem_ren`. No other combinational path runs input to output.
- Reset during WAIT/RESP aborts the read and no `mem_valid` is produced.

## Configuration
- `MEM_WSTRB_EN` defined: adds input `mem_wstrb[3:0]`. Bit i enables write of byte `mem_dout[8i+7:8i]`. `mem_wstrb=0` with `mem_wen=1` is a legal no-op write.
- Undefined: the port is absent and every write updates all 4 bytes.

## Test plan
- **Reset:** assert `cpu_rst` asynchronously mid-cycle → `mem_din=0`, `mem_valid=0`, `mem_err=0`, `mem_stall=0` immediately.
- **Write then read (LATENCY=2):** write 0x1234_5678 to 0x10, then read 0x10 → `mem_stall=1` in cycles 0–1; cycle 2 has `mem_valid=1`, `mem_din=0x1234_5678`.
- **Back-to-back reads:** reads of 0x0 (=0xA) and 0x4 (=0xB) → valid pulses in cycles 2 and 5 with 0xA and 0xB; `mem_din` holds 0xA in cycles 3–4.
- **Misaligned write:** write 0xFFFF_FFFF to 0x13 → `mem_err=1` next cycle and persists; a later read of 0x10 still returns 0x1234_5678.
- **Freeze and abort:**
  - `cpu_en=0` for 3 cycles in WAIT → valid delayed by exactly 3 cycles.
  - Separate run: `cpu_rst` pulse in WAIT → no valid; next read works normally.
- **With `MEM_WSTRB_EN`:** write 0xAABB_CCDD with strobe 4'b0011 over 0x1234_5678 → readback 0x1234_CCDD.
